// File: rtl/intra_sad_accumulator_if.sv
// Row-streaming interface between the intra predictor row buffers and the SAD accumulator.
// The master side supplies rows and start; the slave side returns per-mode block SADs.
interface intra_sad_accumulator_if #(
    parameter int MB_SIZE_W = 8,
    parameter int NUM_MODES = 8,
    parameter int SAD_WIDTH = 8
);
    logic                 start;
    logic                 row_valid;
    logic                 row_ready;
    logic [7:0]           orig_row  [MB_SIZE_W];
    logic [7:0]           pred_rows [NUM_MODES*MB_SIZE_W];
    logic [SAD_WIDTH-1:0] sads      [NUM_MODES];
    logic                 sads_valid;
    logic                 busy;

    modport master (
        output start, row_valid, orig_row, pred_rows,
        input  row_ready, sads, sads_valid, busy
    );

    modport slave (
        input  start, row_valid, orig_row, pred_rows,
        output row_ready, sads, sads_valid, busy
    );
endinterface

// File: rtl/intra_sad_accumulator.sv
// Per-mode SAD accumulator: one row per beat, two-stage pipeline (row SAD, block accumulate),
// saturated per-mode result presented with a one-cycle valid pulse.
module intra_sad_accumulator #(
    parameter int MB_SIZE_L = 8,
    parameter int MB_SIZE_W = 8,
    parameter int NUM_MODES = 8,
    parameter int SAD_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    intra_sad_accumulator_if.slave bus
);
    localparam int RS_W  = 8 + $clog2(MB_SIZE_W);
    localparam int ACC_W = 8 + $clog2(MB_SIZE_L*MB_SIZE_W);
    localparam int CNT_W = (MB_SIZE_L > 1) ? $clog2(MB_SIZE_L) : 1;
    localparam logic [ACC_W+SAD_WIDTH-1:0] SAT = {{ACC_W{1'b0}}, {SAD_WIDTH{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH, S_DONE} state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     row_cnt;
    logic [RS_W-1:0]      rowsad_d [NUM_MODES];
    logic [RS_W-1:0]      rowsad_q [NUM_MODES];
    logic                 s1_valid;
    logic [ACC_W-1:0]     acc      [NUM_MODES];
    logic [SAD_WIDTH-1:0] sads_q   [NUM_MODES];
    logic                 sads_valid_q;
    logic                 row_ready;
    logic                 xfer;
    logic                 last_row;

    // Transfer is derived from state rather than row_ready to keep it free of the FSM comb path.
    assign xfer     = enable && bus.row_valid && (state == S_ACCUM);
    assign last_row = (row_cnt == CNT_W'(MB_SIZE_L-1));

    always_comb begin
        for (int unsigned m = 0; m < NUM_MODES; m++) begin
            rowsad_d[m] = '0;
            for (int unsigned c = 0; c < MB_SIZE_W; c++) begin
                if (bus.orig_row[c] >= bus.pred_rows[m*MB_SIZE_W+c])
                    rowsad_d[m] = rowsad_d[m]
                                + RS_W'(bus.orig_row[c] - bus.pred_rows[m*MB_SIZE_W+c]);
                else
                    rowsad_d[m] = rowsad_d[m]
                                + RS_W'(bus.pred_rows[m*MB_SIZE_W+c] - bus.orig_row[c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else if (enable)
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        row_ready  = 1'b0;
        case (state)
            S_IDLE:  if (bus.start) state_next = S_ACCUM;
            S_ACCUM: begin
                row_ready = 1'b1;
                if (xfer && last_row) state_next = S_FLUSH;
            end
            S_FLUSH: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt      <= '0;
            s1_valid     <= 1'b0;
            rowsad_q     <= '{default: '0};
            acc          <= '{default: '0};
            sads_q       <= '{default: '0};
            sads_valid_q <= 1'b0;
        end else if (enable) begin
            s1_valid     <= xfer;
            sads_valid_q <= (state == S_DONE);
            if (xfer) begin
                rowsad_q <= rowsad_d;
                row_cnt  <= row_cnt + 1'b1;
            end
            if (state == S_IDLE && bus.start) begin
                acc     <= '{default: '0};
                row_cnt <= '0;
            end else if (s1_valid) begin
                for (int unsigned m = 0; m < NUM_MODES; m++)
                    acc[m] <= acc[m] + ACC_W'(rowsad_q[m]);
            end
            if (state == S_DONE) begin
                for (int unsigned m = 0; m < NUM_MODES; m++) begin
                    if ({{SAD_WIDTH{1'b0}}, acc[m]} > SAT)
                        sads_q[m] <= '1;
                    else
                        sads_q[m] <= SAD_WIDTH'(acc[m]);
                end
            end
        end
    end

    assign bus.row_ready  = row_ready;
    assign bus.sads       = sads_q;
    assign bus.sads_valid = sads_valid_q;
    assign bus.busy       = (state != S_IDLE) || sads_valid_q;
endmodule

// File: tb/tb_intra_sad_accumulator.sv
// Directed bench for intra_sad_accumulator: table of uniform-fill blocks plus hand-written
// sequences for gapped rows, clock-enable freezes, start during a block and reset abort.
module tb_intra_sad_accumulator;
    localparam int L = 8;
    localparam int W = 8;
    localparam int M = 8;

    logic clk;
    logic reset;
    logic enable;

    intra_sad_accumulator_if #(.MB_SIZE_W(W), .NUM_MODES(M), .SAD_WIDTH(8)) bus ();

    intra_sad_accumulator #(
        .MB_SIZE_L(L),
        .MB_SIZE_W(W),
        .NUM_MODES(M),
        .SAD_WIDTH(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [7:0]      orig;
        logic [7:0][7:0] pred;
        logic [7:0][7:0] exp;
        logic            gaps;
        logic            fr_mid;
        logic            fr_done;
    } vec_t;

    vec_t            vecs [5];
    logic [7:0]      blk_orig [L][W];
    logic [7:0]      blk_pred [L][M*W];
    logic [7:0][7:0] prev_sads;
    logic [7:0][7:0] e;
    int              checks;
    int              errors;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0][7:0] get_sads();
        logic [7:0][7:0] s;
        for (int m = 0; m < M; m++) s[m] = bus.sads[m];
        return s;
    endfunction

    task automatic set_row(input int r);
        for (int c = 0; c < W; c++) bus.orig_row[c] = blk_orig[r][c];
        for (int i = 0; i < M*W; i++) bus.pred_rows[i] = blk_pred[r][i];
    endtask

    task automatic fill_uniform(input logic [7:0] o, input logic [7:0][7:0] p);
        for (int r = 0; r < L; r++)
            for (int c = 0; c < W; c++) begin
                blk_orig[r][c] = o;
                for (int m = 0; m < M; m++) blk_pred[r][m*W+c] = p[m];
            end
    endtask

    task automatic run_block(input logic [7:0][7:0] exp, input bit gaps, input bit fr_mid,
                             input bit fr_done, input bit start_mid, input string tag);
        int lat;
        int xfers;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk({tag, " busy_after_start"}, 64'(bus.busy), 64'd1);
        chk({tag, " sads_hold_on_start"}, get_sads(), prev_sads);
        xfers = 0;
        for (int r = 0; r < L; r++) begin
            if (gaps) begin
                bus.row_valid = 1'b0;
                repeat (r % 4) step();
            end
            set_row(r);
            bus.row_valid = 1'b1;
            if (fr_mid && r == 4) begin
                enable = 1'b0;
                repeat (5) step();
                enable = 1'b1;
            end
            if (start_mid && r == 2) bus.start = 1'b1;
            lat = 0;
            while (!bus.row_ready && lat < 20) begin
                step();
                lat++;
            end
            if (bus.row_ready) xfers++;
            step();
            bus.start     = 1'b0;
            bus.row_valid = 1'b0;
        end
        chk({tag, " rows_accepted"}, 64'(xfers), 64'(L));
        chk({tag, " flush_not_ready"}, 64'(bus.row_ready), 64'd0);
        lat = 1;
        while (!bus.sads_valid && lat < 12) begin
            step();
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'd3);
        chk({tag, " sads"}, get_sads(), exp);
        chk({tag, " busy_on_valid"}, 64'(bus.busy), 64'd1);
        if (fr_done) begin
            enable = 1'b0;
            repeat (4) step();
            chk({tag, " valid_held_frozen"}, {62'd0, bus.sads_valid, bus.busy}, 64'd3);
            enable = 1'b1;
        end
        step();
        chk({tag, " valid_drop"}, 64'(bus.sads_valid), 64'd0);
        chk({tag, " busy_drop"}, 64'(bus.busy), 64'd0);
        prev_sads = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        checks = 0;
        errors = 0;
        prev_sads = '0;

        // table: uniform-fill blocks
        for (int i = 0; i < 5; i++) vecs[i] = '0;
        vecs[0].orig = 8'd37;
        for (int m = 0; m < M; m++) vecs[0].pred[m] = 8'd37;
        vecs[1].orig = 8'd100;
        for (int m = 0; m < M; m++) vecs[1].pred[m] = 8'(100 + m);
        vecs[1].exp  = {8'd255, 8'd255, 8'd255, 8'd255, 8'd192, 8'd128, 8'd64, 8'd0};
        vecs[2].orig = 8'd255;
        for (int m = 0; m < M; m++) vecs[2].pred[m] = (m == 5) ? 8'd0 : 8'd255;
        vecs[2].exp[5] = 8'd255;
        vecs[3].orig = 8'd50;
        for (int m = 0; m < M; m++) vecs[3].pred[m] = 8'd50;
        vecs[3].pred[3] = 8'd47;
        vecs[3].pred[6] = 8'd51;
        vecs[3].exp[3]  = 8'd192;
        vecs[3].exp[6]  = 8'd64;
        vecs[3].fr_mid  = 1'b1;
        vecs[3].fr_done = 1'b1;
        vecs[4] = vecs[1];
        vecs[4].gaps = 1'b1;

        reset = 1'b1;
        enable = 1'b1;
        bus.start = 1'b0;
        bus.row_valid = 1'b0;
        for (int c = 0; c < W; c++) bus.orig_row[c] = '0;
        for (int i = 0; i < M*W; i++) bus.pred_rows[i] = '0;
        repeat (3) step();
        chk("reset sads", get_sads(), 64'd0);
        chk("reset ctrl", {61'd0, bus.sads_valid, bus.row_ready, bus.busy}, 64'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            fill_uniform(vecs[i].orig, vecs[i].pred);
            run_block(vecs[i].exp, vecs[i].gaps, vecs[i].fr_mid, vecs[i].fr_done, 1'b0,
                      $sformatf("vec%0d", i));
        end

        // single-pixel difference on mode 2, rows with idle gaps
        for (int r = 0; r < L; r++)
            for (int c = 0; c < W; c++) begin
                blk_orig[r][c] = 8'((r * 29 + c * 7) % 200);
                for (int m = 0; m < M; m++) blk_pred[r][m*W+c] = blk_orig[r][c];
            end
        blk_pred[5][2*W+3] = blk_orig[5][3] + 8'd1;
        e = '0;
        e[2] = 8'd1;
        run_block(e, 1'b1, 1'b0, 1'b0, 1'b0, "pix_gaps");

        // mode 7 differs by 2 everywhere; first attempt aborted by reset after row 4
        for (int r = 0; r < L; r++)
            for (int c = 0; c < W; c++) begin
                blk_orig[r][c] = 8'(r * 8 + c);
                for (int m = 0; m < M; m++)
                    blk_pred[r][m*W+c] = (m == 7) ? 8'(r * 8 + c + 2) : 8'(r * 8 + c);
            end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int r = 0; r < 4; r++) begin
            set_row(r);
            bus.row_valid = 1'b1;
            step();
        end
        bus.row_valid = 1'b0;
        reset = 1'b1;
        step();
        chk("abort sads", get_sads(), 64'd0);
        chk("abort ctrl", {61'd0, bus.sads_valid, bus.row_ready, bus.busy}, 64'd0);
        reset = 1'b0;
        seen = 0;
        repeat (8) begin
            step();
            if (bus.sads_valid) seen++;
        end
        chk("abort no_pulse", 64'(seen), 64'd0);
        prev_sads = '0;
        e = '0;
        e[7] = 8'd128;
        run_block(e, 1'b0, 1'b0, 1'b0, 1'b1, "mode7_startmid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
